// File: rtl/clock_key_ctrl.sv
// Push-button controller: synchronizes and debounces a raw key, emits a one-cycle
// step strobe per press, flags a long press, and counts strobes.
// Optional feature macro: AUTO_REPEAT_EN (when defined, a long press auto-repeats
// step strobes every REPEAT_CYCLES; otherwise one strobe per press).
module clock_key_ctrl #(
    parameter int unsigned DB_CYCLES     = 500000,
    parameter int unsigned HOLD_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       step_pulse,
    output logic       key_db,
    output logic       long_press,
    output logic [7:0] pulse_cnt
);

    localparam int unsigned CntW = 25;
    localparam int unsigned CntMax = (1 << CntW) - 1;

    // All timing parameters must fit the 25-bit timer and be at least 2.
    if (DB_CYCLES < 2 || DB_CYCLES > CntMax || HOLD_CYCLES < 2 || HOLD_CYCLES > CntMax ||
        REPEAT_CYCLES < 2 || REPEAT_CYCLES > CntMax) begin : g_param_check
        $error("clock_key_ctrl: timing parameter out of range 2..2^25-1");
    end

    localparam logic [CntW-1:0] DbLast   = CntW'(DB_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [CntW-1:0] RepLast  = CntW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        StIdle,
        StPressDb,
        StHeld,
        StRepeat,
        StReleaseDb
    } state_e;

    logic            key_meta_q;
    logic            key_s_q;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            step_q, step_d;
    logic            db_q, db_d;
    logic            lp_q, lp_d;
    logic [7:0]      pcnt_q;
`ifdef AUTO_REPEAT_EN
    // Remembers whether RELEASE_DB was entered from REPEAT, so a bounce returns there.
    logic            ret_rep_q, ret_rep_d;
`endif

    // Two-flop synchronizer for the asynchronous key input.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta_q <= 1'b0;
            key_s_q    <= 1'b0;
        end else begin
            key_meta_q <= key_in;
            key_s_q    <= key_meta_q;
        end
    end

    // Next-state, timer and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        step_d  = 1'b0;
        lp_d    = lp_q;
`ifdef AUTO_REPEAT_EN
        ret_rep_d = ret_rep_q;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (key_s_q) state_d = StPressDb;
            end
            StPressDb: begin
                if (!key_s_q) begin
                    state_d = StIdle;
                end else if (cnt_q == DbLast) begin
                    state_d = StHeld;
                    step_d  = 1'b1;
                end
            end
            StHeld: begin
                if (!key_s_q) begin
                    state_d = StReleaseDb;
`ifdef AUTO_REPEAT_EN
                    ret_rep_d = 1'b0;
`endif
                end else if (cnt_q == HoldLast) begin
                    lp_d = 1'b1;
`ifdef AUTO_REPEAT_EN
                    state_d = StRepeat;
                    step_d  = 1'b1;
`else
                    // Park the timer; nothing further happens until release.
                    cnt_d = cnt_q;
`endif
                end
            end
`ifdef AUTO_REPEAT_EN
            StRepeat: begin
                if (!key_s_q) begin
                    state_d   = StReleaseDb;
                    ret_rep_d = 1'b1;
                end else if (cnt_q == RepLast) begin
                    step_d = 1'b1;
                    cnt_d  = '0;
                end
            end
`endif
            StReleaseDb: begin
                if (key_s_q) begin
                    // Bounce: resume where we were, without a strobe.
`ifdef AUTO_REPEAT_EN
                    state_d = ret_rep_q ? StRepeat : StHeld;
`else
                    state_d = StHeld;
`endif
                end else if (cnt_q == DbLast) begin
                    state_d = StIdle;
                    lp_d    = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                lp_d    = 1'b0;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
        db_d = (state_d == StHeld) || (state_d == StRepeat) || (state_d == StReleaseDb);
    end

    // State, timer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            db_q    <= 1'b0;
            lp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            db_q    <= db_d;
            lp_q    <= lp_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    // Return-target flag for release bounces.
    always_ff @(posedge clk) begin
        if (rst) ret_rep_q <= 1'b0;
        else     ret_rep_q <= ret_rep_d;
    end
`endif

    // Strobe counter lags the strobe by one cycle and wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) pcnt_q <= 8'd0;
        else     pcnt_q <= pcnt_q + {7'd0, step_q};
    end

    assign step_pulse = step_q;
    assign key_db     = db_q;
    assign long_press = lp_q;
    assign pulse_cnt  = pcnt_q;

endmodule

// File: tb/tb_clock_key_ctrl.sv
// Scoreboard bench for clock_key_ctrl with small timing parameters.
module tb_clock_key_ctrl;

    localparam int unsigned Db   = 4;
    localparam int unsigned Hold = 20;
    localparam int unsigned Rep  = 5;
`ifdef AUTO_REPEAT_EN
    localparam bit Auto = 1'b1;
`else
    localparam bit Auto = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_in = 1'b0;
    logic       step_pulse;
    logic       key_db;
    logic       long_press;
    logic [7:0] pulse_cnt;

    clock_key_ctrl #(
        .DB_CYCLES    (Db),
        .HOLD_CYCLES  (Hold),
        .REPEAT_CYCLES(Rep)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .step_pulse(step_pulse),
        .key_db    (key_db),
        .long_press(long_press),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit started  = 1'b0;

    // Reference model state: key history, run lengths, debounced level, long press.
    logic       k1 = 0, k2 = 0, ks;
    bit         m_db = 0, m_lp = 0, m_rep = 0, m_stp = 0;
    int         hi_run = 0, lo_run = 0, t = 0;
    logic [7:0] m_pcnt = 0;
    int         sb_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: a press is debounced after Db+1 consecutive high samples of
    // the synchronized key, released after Db+1 low samples; held time counts high
    // samples since (re)entry. Expected strobes are pushed with their cycle number.
    always @(posedge clk) begin
        cyc++;
        started = 1'b1;
        if (rst) begin
            k1 = 0; k2 = 0; m_db = 0; m_lp = 0; m_rep = 0; m_stp = 0;
            hi_run = 0; lo_run = 0; t = 0; m_pcnt = 0;
        end else begin
            ks = k2; k2 = k1; k1 = key_in;
            m_pcnt = m_pcnt + 8'(m_stp);
            m_stp = 0;
            if (!m_db) begin
                hi_run = ks ? hi_run + 1 : 0;
                if (hi_run == Db + 1) begin
                    m_db = 1; m_stp = 1; t = 0; lo_run = 0; m_rep = 0; hi_run = 0;
                end
            end else if (!ks) begin
                lo_run++;
                if (lo_run == Db + 1) begin
                    m_db = 0; m_lp = 0; lo_run = 0;
                end
            end else if (lo_run != 0) begin
                lo_run = 0; t = 0;
            end else begin
                t++;
                if (!m_rep && t == Hold) begin
                    m_lp = 1; t = 0;
                    if (Auto) begin m_rep = 1; m_stp = 1; end
                end else if (m_rep && t == Rep) begin
                    m_stp = 1; t = 0;
                end
            end
            if (m_stp) sb_q.push_back(cyc);
        end
    end

    // Monitor: compares levels every cycle and matches strobes against the queue.
    always @(negedge clk) begin
        if (started) begin
            check("key_db", int'(key_db === 1'b1), int'(m_db));
            check("long_press", int'(long_press === 1'b1), int'(m_lp));
            check("pulse_cnt", (^pulse_cnt === 1'bx) ? -1 : int'(pulse_cnt), int'(m_pcnt));
            while (sb_q.size() > 0 && sb_q[0] < cyc) begin
                check("missing_step_at", -1, sb_q[0]);
                void'(sb_q.pop_front());
            end
            if (step_pulse === 1'b1) begin
                if (sb_q.size() == 0) check("unexpected_step", cyc, -1);
                else check("step_cycle", cyc, sb_q.pop_front());
            end else begin
                check("step_low_known", int'(step_pulse === 1'b0), 1);
            end
        end
    end

    task automatic drive(input logic v, input int n);
        key_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 5);
        drive(1, 3);  drive(0, 12);          // too short: no strobe
        drive(1, 15); drive(0, 12);          // single press
        drive(1, 60); drive(0, 12);          // long press
        drive(1, 40); drive(0, 2);           // release bounce
        drive(1, 10); drive(0, 12);
        drive(1, 35);                        // reset in the middle of a long hold
        rst = 1'b1; drive(1, 1); rst = 1'b0;
        drive(1, 40); drive(0, 12);
        for (int i = 0; i < 40; i++) begin   // random bouncy presses
            drive(1, $urandom_range(1, 70));
            drive(0, $urandom_range(1, 12));
        end
        drive(0, 12);
        for (int i = 0; i < 256; i++) begin  // counter wrap
            drive(1, 10);
            drive(0, 10);
        end
        drive(0, 20);
        check("queue_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_key_ctrl.md
CLOCK_KEY_CTRL -- requirements
Module: clock_key_ctrl

Interface
REQ-001 Parameters: DB_CYCLES, default 500000, debounce window in clk cycles (10 ms at 50 MHz).
REQ-002 Parameters: HOLD_CYCLES, default 25000000, press duration before long-press/auto-repeat.
REQ-003 Parameters: REPEAT_CYCLES, default 5000000, auto-repeat step interval.
REQ-004 All three parameters SHALL be in the range 2..2^25-1; the internal timer is 25 bits.
REQ-005 Port: clk, input, 1, system clock; one clock domain; reset is synchronous and active-high.
REQ-006 Port: rst, input, 1, synchronous active-high reset.
REQ-007 Port: key_in, input, 1, raw asynchronous push-button, active-high, may bounce.
REQ-008 Port: step_pulse, output, 1, one-cycle strobe; drives adjust inputs such as change_in.
REQ-009 Port: key_db, output, 1, debounced key level.
REQ-010 Port: long_press, output, 1, high while the key has been held at least HOLD_CYCLES.
REQ-011 Port: pulse_cnt, output, 8, count of step_pulse strobes since reset; wraps.

Function
REQ-012 key_in SHALL pass through a 2-flop synchronizer; key_s denotes the second flop output, and all FSM decisions use key_s only.
REQ-013 FSM states: IDLE, PRESS_DB, HELD, REPEAT, RELEASE_DB; timer cnt is cleared on every state change.
REQ-014 IDLE: key_db=0 and long_press=0; key_s=1 SHALL move to PRESS_DB.
REQ-015 PRESS_DB, key_s=0: return to IDLE with no output change.
REQ-016 PRESS_DB, key_s=1: cnt increments; at cnt==DB_CYCLES-1, move to HELD.
REQ-017 HELD: key_db=1; step_pulse is high for exactly the first cycle spent in HELD when entered from PRESS_DB.
REQ-018 HELD, key_s=0: move to RELEASE_DB.
REQ-019 HELD, key_s=1: cnt increments; at cnt==HOLD_CYCLES-1, long_press is set; see REQ-027/028 for the state transition.
REQ-020 REPEAT, key_s=1: cnt increments; at cnt==REPEAT_CYCLES-1, step_pulse is high for one cycle and cnt is cleared.
REQ-021 REPEAT, key_s=0: move to RELEASE_DB.
REQ-022 RELEASE_DB: key_db stays 1.
REQ-023 RELEASE_DB, key_s=0: held for DB_CYCLES consecutive cycles -> IDLE, key_db=0, long_press=0.
REQ-024 RELEASE_DB, key_s=1 (bounce): return to the state it was entered from (HELD or REPEAT) with cnt cleared, no step_pulse and long_press unchanged.
REQ-025 pulse_cnt SHALL increment by 1 in the cycle after each step_pulse; 255 wraps to 0.
REQ-026 step_pulse is never high for two consecutive cycles; all outputs are registered.

Configuration
REQ-027 With macro AUTO_REPEAT_EN defined: HELD moves to REPEAT at long_press set, with step_pulse high that cycle.
REQ-028 Without AUTO_REPEAT_EN: REPEAT state is not built; HELD stays in HELD after long_press is set; exactly one step_pulse per press; long_press behaves identically.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, clear cnt, both synchronizer flops, and pulse_cnt, and set step_pulse=key_db=long_press=0 from the next cycle, regardless of state.
REQ-030 rst has priority over all FSM events in the same cycle.

Verification (DB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5, AUTO_REPEAT_EN defined unless noted)
REQ-031 key_in high for 3 cycles, then low -> no step_pulse, key_db stays 0, pulse_cnt=0.
REQ-032 key_in high for 15 cycles, then low -> exactly one step_pulse, 7 clocks after the key_in rise; key_db falls after the release debounce; pulse_cnt=1.
REQ-033 key_in held 60 cycles -> first step_pulse, then long_press rises 20 cycles later with a step, then further steps exactly 5 cycles apart until release.
REQ-034 During RELEASE_DB, key_in low 2 cycles then high again -> no extra step_pulse, key_db stays 1, long_press unchanged.
REQ-035 rst pulsed for 1 cycle mid-REPEAT -> next cycle all outputs 0 and pulse_cnt=0; with key still held, a new press is detected and debounced afresh.
REQ-036 Without AUTO_REPEAT_EN, 256 presses of 10 cycles each -> pulse_cnt wraps to 0 and no press produces more than one step_pulse.
